// File: rtl/core_frame_receiver_pkg.sv
// -----------------------------------------------------------------------------
// core_frame_receiver_pkg
//   Shared definitions for the instruction-load protocol between the Task
//   Scheduler and the per-core frame receivers: frame geometry defaults,
//   the receiver state encoding, and the slice macros that both ends use to
//   locate beats, instruction words and per-core R0 init values.
//   Optional feature macro used by the receiver: CORE_FRAME_RX_CHECK_EN.
// -----------------------------------------------------------------------------
`ifndef CORE_FRAME_RECEIVER_PKG_SV
`define CORE_FRAME_RECEIVER_PKG_SV

// Beat k of a frame inside a flattened frame vector.
`define CFR_BEAT_SLICE(k, bus_w)   ((k)*(bus_w)) +: (bus_w)
// Word j inside a beat or inside a flattened frame (LSB word first).
`define CFR_WORD_SLICE(j, insn_w)  ((j)*(insn_w)) +: (insn_w)
// R0 init value of core c inside the Init_R0 broadcast vector.
`define CFR_R0_SLICE(c, reg_w)     ((c)*(reg_w)) +: (reg_w)

package core_frame_receiver_pkg;

    localparam int CFR_NUM_CORES      = 4;
    localparam int CFR_INSN_LOAD_TIME = 4;
    localparam int CFR_INSN_BUS_W     = 64;
    localparam int CFR_INSN_W         = 16;
    localparam int CFR_CNT_W          = 2;
    localparam int CFR_REG_W          = 8;
    localparam int CFR_NWORDS         = CFR_INSN_LOAD_TIME * CFR_INSN_BUS_W / CFR_INSN_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } cfr_state_e;

    // Number of instruction words carried by one frame.
    function automatic int cfr_nwords(input int load_time, input int bus_w, input int insn_w);
        return load_time * bus_w / insn_w;
    endfunction

endpackage

`endif

// File: rtl/core_frame_buf.sv
// -----------------------------------------------------------------------------
// core_frame_buf
//   Frame storage: INSN_LOAD_TIME x INSN_BUS_W register file. One beat write
//   port (indexed by bus beat) and one combinational word read port (indexed
//   by the word position inside the frame). Contents are not reset.
//   Ports:
//     clk       clock
//     we_i      write enable for one beat
//     waddr_i   beat index
//     wdata_i   beat data
//     raddr_i   word index within the frame
//     rdata_o   selected instruction word
// -----------------------------------------------------------------------------
module core_frame_buf
    import core_frame_receiver_pkg::*;
#(
    parameter int INSN_LOAD_TIME = CFR_INSN_LOAD_TIME,
    parameter int INSN_BUS_W     = CFR_INSN_BUS_W,
    parameter int INSN_W         = CFR_INSN_W,
    parameter int CNT_W          = CFR_CNT_W,
    parameter int PC_W           = $clog2(cfr_nwords(INSN_LOAD_TIME, INSN_BUS_W, INSN_W))
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [CNT_W-1:0]      waddr_i,
    input  logic [INSN_BUS_W-1:0] wdata_i,
    input  logic [PC_W-1:0]       raddr_i,
    output logic [INSN_W-1:0]     rdata_o
);

    logic [INSN_BUS_W-1:0]                mem_q [INSN_LOAD_TIME];
    logic [INSN_LOAD_TIME*INSN_BUS_W-1:0] flat_s;

    // Beat write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Flatten beats so that word n sits at bits [n*INSN_W +: INSN_W].
    always_comb begin
        flat_s = '0;
        for (int k = 0; k < INSN_LOAD_TIME; k++) begin
            flat_s[`CFR_BEAT_SLICE(k, INSN_BUS_W)] = mem_q[k];
        end
    end

    assign rdata_o = flat_s[`CFR_WORD_SLICE(raddr_i, INSN_W)];

endmodule

// File: rtl/core_frame_receiver.sv
// -----------------------------------------------------------------------------
// core_frame_receiver
//   Core-side end of the Task Scheduler instruction-load protocol. Captures a
//   multi-beat frame while Start[CORE_ID] is high, latches the optional R0
//   init value, then issues the frame's words through a valid/ready fetch
//   port until the pipeline reports core_done.
//   Optional feature (macro CORE_FRAME_RX_CHECK_EN): sticky protocol error
//   detection on err, with strict beat sequencing. Without it err is 0.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     start             Start vector (bit CORE_ID used)
//     insn_load_cnt     beat index of insn_data
//     insn_data         frame beat
//     init_r0_vect      per-core R0 init enable
//     init_r0           per-core R0 init values
//     ready             high when a frame may be loaded
//     fetch_valid/insn/pc, fetch_ready   instruction issue handshake
//     core_done         pipeline finished the frame
//     r0_load, r0_value one-cycle R0 write request and its value
//     err               sticky protocol error
// -----------------------------------------------------------------------------
module core_frame_receiver
    import core_frame_receiver_pkg::*;
#(
    parameter int CORE_ID        = 0,
    parameter int NUM_CORES      = CFR_NUM_CORES,
    parameter int INSN_LOAD_TIME = CFR_INSN_LOAD_TIME,
    parameter int INSN_BUS_W     = CFR_INSN_BUS_W,
    parameter int INSN_W         = CFR_INSN_W,
    parameter int CNT_W          = CFR_CNT_W,
    parameter int REG_W          = CFR_REG_W,
    // Derived; not meant to be overridden.
    parameter int NWORDS         = cfr_nwords(INSN_LOAD_TIME, INSN_BUS_W, INSN_W),
    parameter int PC_W           = $clog2(NWORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CORES-1:0]       start,
    input  logic [CNT_W-1:0]           insn_load_cnt,
    input  logic [INSN_BUS_W-1:0]      insn_data,
    input  logic [NUM_CORES-1:0]       init_r0_vect,
    input  logic [NUM_CORES*REG_W-1:0] init_r0,
    output logic                       ready,
    output logic                       fetch_valid,
    output logic [INSN_W-1:0]          fetch_insn,
    output logic [PC_W-1:0]            fetch_pc,
    input  logic                       fetch_ready,
    input  logic                       core_done,
    output logic                       r0_load,
    output logic [REG_W-1:0]           r0_value,
    output logic                       err
);

    // Beat counter holds up to INSN_LOAD_TIME, hence one extra bit.
    localparam int                 BCNT_W          = CNT_W + 1;
    localparam logic [BCNT_W-1:0]  BEATS_PER_FRAME = BCNT_W'(INSN_LOAD_TIME);
    localparam logic [PC_W-1:0]    PC_LAST         = PC_W'(NWORDS - 1);

    cfr_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic              r0_load_q, r0_load_d;
    logic              r0_en_q, r0_en_d;
    logic [REG_W-1:0]  r0_value_q, r0_value_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              st_s;
    logic              r0_en_in_s;
    logic [REG_W-1:0]  r0_in_s;
    logic              buf_we_s;
    logic              beat_ok_s;
    logic              run_enter_s;
    logic              go_idle_s;
    logic              proto_err_s;
    logic [INSN_W-1:0] rd_word_s;
    logic              unused_ok_s;

    assign st_s        = start[CORE_ID];
    assign r0_en_in_s  = init_r0_vect[CORE_ID];
    assign r0_in_s     = init_r0[`CFR_R0_SLICE(CORE_ID, REG_W)];
    assign unused_ok_s = ^{start, init_r0_vect, init_r0, proto_err_s};

    core_frame_buf #(
        .INSN_LOAD_TIME (INSN_LOAD_TIME),
        .INSN_BUS_W     (INSN_BUS_W),
        .INSN_W         (INSN_W),
        .CNT_W          (CNT_W),
        .PC_W           (PC_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we_s),
        .waddr_i (insn_load_cnt),
        .wdata_i (insn_data),
        .raddr_i (fetch_pc_q),
        .rdata_o (rd_word_s)
    );

    // Next-state and output-register logic for the load/run FSM.
    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        r0_load_d     = 1'b0;
        r0_en_d       = r0_en_q;
        r0_value_d    = r0_value_q;
        beat_cnt_d    = beat_cnt_q;
        buf_we_s      = 1'b0;
        beat_ok_s     = 1'b0;
        run_enter_s   = 1'b0;
        go_idle_s     = 1'b0;
        proto_err_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (st_s) begin
`ifdef CORE_FRAME_RX_CHECK_EN
                    beat_ok_s   = (insn_load_cnt == {CNT_W{1'b0}});
                    proto_err_s = !beat_ok_s;
`else
                    beat_ok_s   = 1'b1;
`endif
                end else begin
                    beat_ok_s   = 1'b0;
                end
                if (beat_ok_s) begin
                    buf_we_s   = 1'b1;
                    r0_en_d    = r0_en_in_s;
                    r0_value_d = r0_in_s;
                    beat_cnt_d = BCNT_W'(1);
                    if (BCNT_W'(1) == BEATS_PER_FRAME) begin
                        run_enter_s = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!st_s) begin
                    // Start withdrawn before the last beat: discard the frame.
                    go_idle_s = 1'b1;
`ifdef CORE_FRAME_RX_CHECK_EN
                    proto_err_s = 1'b1;
`endif
                end else begin
`ifdef CORE_FRAME_RX_CHECK_EN
                    // Beats written so far equals the index expected next.
                    beat_ok_s   = (insn_load_cnt == beat_cnt_q[CNT_W-1:0]);
                    proto_err_s = !beat_ok_s;
`else
                    beat_ok_s   = 1'b1;
`endif
                    if (beat_ok_s) begin
                        buf_we_s   = 1'b1;
                        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                        if (beat_cnt_d == BEATS_PER_FRAME) begin
                            run_enter_s = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
            end
            ST_RUN: begin
`ifdef CORE_FRAME_RX_CHECK_EN
                proto_err_s = st_s;
`endif
                // core_done wins over a simultaneous handshake.
                if (core_done) begin
                    go_idle_s = 1'b1;
                end else if (fetch_valid_q && fetch_ready) begin
                    if (fetch_pc_q == PC_LAST) begin
                        fetch_valid_d = 1'b0;
                        state_d       = ST_DRAIN;
                    end else begin
                        fetch_pc_d = fetch_pc_q + PC_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
`ifdef CORE_FRAME_RX_CHECK_EN
                proto_err_s = st_s;
`endif
                if (core_done) begin
                    go_idle_s = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                go_idle_s = 1'b1;
            end
        endcase

        if (run_enter_s) begin
            state_d       = ST_RUN;
            ready_d       = 1'b0;
            fetch_valid_d = 1'b1;
            fetch_pc_d    = {PC_W{1'b0}};
            r0_load_d     = r0_en_d;
        end else if (go_idle_s) begin
            state_d       = ST_IDLE;
            ready_d       = 1'b1;
            fetch_valid_d = 1'b0;
            fetch_pc_d    = {PC_W{1'b0}};
            beat_cnt_d    = {BCNT_W{1'b0}};
        end else begin
            beat_cnt_d    = beat_cnt_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b1;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= {PC_W{1'b0}};
            r0_load_q     <= 1'b0;
            r0_en_q       <= 1'b0;
            r0_value_q    <= {REG_W{1'b0}};
            beat_cnt_q    <= {BCNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            r0_load_q     <= r0_load_d;
            r0_en_q       <= r0_en_d;
            r0_value_q    <= r0_value_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

`ifdef CORE_FRAME_RX_CHECK_EN
    logic err_q;

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | proto_err_s;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ready       = ready_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    // Word read is combinational from the buffer; forced to 0 when nothing is issued.
    assign fetch_insn  = fetch_valid_q ? rd_word_s : {INSN_W{1'b0}};
    assign r0_load     = r0_load_q;
    assign r0_value    = r0_value_q;

endmodule

// File: tb/tb_core_frame_receiver.sv
module tb_core_frame_receiver;

    logic        clk;
    logic        reset;
    logic [3:0]  start;
    logic [1:0]  insn_load_cnt;
    logic [63:0] insn_data;
    logic [3:0]  init_r0_vect;
    logic [31:0] init_r0;
    logic        ready;
    logic        fetch_valid;
    logic [15:0] fetch_insn;
    logic [3:0]  fetch_pc;
    logic        fetch_ready;
    logic        core_done;
    logic        r0_load;
    logic [7:0]  r0_value;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;

`ifdef CORE_FRAME_RX_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    core_frame_receiver #(.CORE_ID(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .insn_load_cnt (insn_load_cnt),
        .insn_data     (insn_data),
        .init_r0_vect  (init_r0_vect),
        .init_r0       (init_r0),
        .ready         (ready),
        .fetch_valid   (fetch_valid),
        .fetch_insn    (fetch_insn),
        .fetch_pc      (fetch_pc),
        .fetch_ready   (fetch_ready),
        .core_done     (core_done),
        .r0_load       (r0_load),
        .r0_value      (r0_value),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_beat(input logic [15:0] base, input int k);
        logic [15:0] w0;
        w0 = base + 16'(4 * k);
        return {w0 + 16'd3, w0 + 16'd2, w0 + 16'd1, w0};
    endfunction

    // Drive one frame for core 1; returns in the first RUN cycle.
    task automatic load_frame(input logic [15:0] base, input logic [3:0] vect, input logic [31:0] r0);
        for (int k = 0; k < 4; k++) begin
            start         = 4'b0010;
            insn_load_cnt = 2'(k);
            insn_data     = mk_beat(base, k);
            init_r0_vect  = vect;
            init_r0       = r0;
            tick();
        end
        start        = 4'b0000;
        insn_data    = 64'd0;
        init_r0_vect = 4'b0000;
        init_r0      = 32'd0;
    endtask

    task automatic test_reset;
        logic [32:0] obs;
        start = 4'b0000; insn_load_cnt = 2'd0; insn_data = 64'd0;
        init_r0_vect = 4'b0000; init_r0 = 32'd0; fetch_ready = 1'b0; core_done = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        obs = {ready, fetch_valid, fetch_pc, fetch_insn, r0_load, r0_value, err};
        vectors++;
        if (obs !== {1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=%h", obs, {1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 8'd0, 1'b0});
        end
    endtask

    task automatic test_basic;
        logic [20:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            start = 4'b0010; insn_load_cnt = 2'(k); insn_data = mk_beat(16'h0000, k);
            tick();
            vectors++;
            if (ready !== (k == 3 ? 1'b0 : 1'b1)) begin
                miscompares++;
                $display("FAIL basic_ready_beat%0d got=%b want=%b", k, ready, (k == 3 ? 1'b0 : 1'b1));
            end
        end
        start = 4'b0000;
        fetch_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_v = {1'b1, 4'(i), 16'(i)};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_insn} !== exp_v) begin
                miscompares++;
                $display("FAIL basic_fetch%0d got=%h want=%h", i, {fetch_valid, fetch_pc, fetch_insn}, exp_v);
            end
            tick();
        end
        tick();
        vectors++;
        if ({ready, fetch_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_drain got=%b want=00", {ready, fetch_valid});
        end
        core_done = 1'b1; tick(); core_done = 1'b0; fetch_ready = 1'b0;
        vectors++;
        if ({ready, fetch_valid, fetch_pc} !== {1'b1, 1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL basic_done got=%h want=%h", {ready, fetch_valid, fetch_pc}, {1'b1, 1'b0, 4'd0});
        end
    endtask

    task automatic test_r0_init;
        load_frame(16'h0000, 4'b0010, 32'h1122_A533);
        vectors++;
        if ({r0_load, r0_value} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL r0_pulse got=%h want=%h", {r0_load, r0_value}, {1'b1, 8'hA5});
        end
        tick();
        vectors++;
        if ({r0_load, r0_value} !== {1'b0, 8'hA5}) begin
            miscompares++;
            $display("FAIL r0_single got=%h want=%h", {r0_load, r0_value}, {1'b0, 8'hA5});
        end
        core_done = 1'b1; tick(); core_done = 1'b0;
        load_frame(16'h0000, 4'b1101, 32'h5A5A_5A5A);
        vectors++;
        if (r0_load !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_no_pulse got=%b want=0", r0_load);
        end
        core_done = 1'b1; tick(); core_done = 1'b0;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL r0_back_idle got=%b want=1", ready);
        end
    endtask

    task automatic test_other_core;
        for (int k = 0; k < 4; k++) begin
            start = 4'b0100; insn_load_cnt = 2'(k); insn_data = mk_beat(16'hBEE0, k);
            tick();
            vectors++;
            if ({ready, fetch_valid, r0_load} !== 3'b100) begin
                miscompares++;
                $display("FAIL other_core%0d got=%b want=100", k, {ready, fetch_valid, r0_load});
            end
        end
        start = 4'b0000;
        tick();
        vectors++;
        if ({ready, fetch_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL other_core_after got=%b want=10", {ready, fetch_valid});
        end
    endtask

    task automatic test_backpressure;
        logic [20:0] exp_v;
        load_frame(16'h0100, 4'b0000, 32'd0);
        fetch_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_v = {1'b1, 4'(i), 16'h0100 + 16'(i)};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_insn} !== exp_v) begin
                miscompares++;
                $display("FAIL bp_fetch%0d got=%h want=%h", i, {fetch_valid, fetch_pc, fetch_insn}, exp_v);
            end
            if (i == 5) begin
                for (int s = 0; s < 3; s++) begin
                    fetch_ready = 1'b0;
                    tick();
                    vectors++;
                    if ({fetch_valid, fetch_pc, fetch_insn} !== exp_v) begin
                        miscompares++;
                        $display("FAIL bp_stall%0d got=%h want=%h", s, {fetch_valid, fetch_pc, fetch_insn}, exp_v);
                    end
                end
                fetch_ready = 1'b1;
            end
            tick();
        end
        fetch_ready = 1'b0;
        core_done = 1'b1; tick(); core_done = 1'b0;
    endtask

    task automatic test_early_done;
        load_frame(16'h0200, 4'b0000, 32'd0);
        fetch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({fetch_pc, fetch_insn} !== {4'(i), 16'h0200 + 16'(i)}) begin
                miscompares++;
                $display("FAIL early_fetch%0d got=%h want=%h", i, {fetch_pc, fetch_insn}, {4'(i), 16'h0200 + 16'(i)});
            end
            if (i == 2) core_done = 1'b1;
            tick();
        end
        core_done = 1'b0;
        vectors++;
        if ({ready, fetch_valid, fetch_pc, fetch_insn} !== {1'b1, 1'b0, 4'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL early_done got=%h want=%h", {ready, fetch_valid, fetch_pc, fetch_insn}, {1'b1, 1'b0, 4'd0, 16'd0});
        end
        tick();
        vectors++;
        if ({ready, fetch_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL early_stay_idle got=%b want=10", {ready, fetch_valid});
        end
        load_frame(16'h0300, 4'b0000, 32'd0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_insn} !== {1'b1, 4'(i), 16'h0300 + 16'(i)}) begin
                miscompares++;
                $display("FAIL reload_fetch%0d got=%h want=%h", i, {fetch_valid, fetch_pc, fetch_insn}, {1'b1, 4'(i), 16'h0300 + 16'(i)});
            end
            tick();
        end
        fetch_ready = 1'b0;
        core_done = 1'b1; tick(); core_done = 1'b0;
    endtask

    task automatic test_protocol_err;
        reset = 1'b1; tick(); reset = 1'b0;
        start = 4'b0010; insn_load_cnt = 2'd0; insn_data = mk_beat(16'h0500, 0);
        tick();
        insn_load_cnt = 2'd2; insn_data = mk_beat(16'h0500, 2);
        tick();
        vectors++;
        if ({ready, err} !== {1'b1, CHECK_ON}) begin
            miscompares++;
            $display("FAIL err_seq got=%b want=%b", {ready, err}, {1'b1, CHECK_ON});
        end
        start = 4'b0000;
        tick();
        vectors++;
        if ({ready, fetch_valid, err} !== {1'b1, 1'b0, CHECK_ON}) begin
            miscompares++;
            $display("FAIL err_abort got=%b want=%b", {ready, fetch_valid, err}, {1'b1, 1'b0, CHECK_ON});
        end
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear got=%b want=0", err);
        end
        load_frame(16'h0400, 4'b0000, 32'd0);
        fetch_ready = 1'b1;
        tick();
        start = 4'b0010; insn_load_cnt = 2'd0; insn_data = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        start = 4'b0000; insn_data = 64'd0;
        vectors++;
        if ({err, fetch_valid, fetch_pc, fetch_insn} !== {CHECK_ON, 1'b1, 4'd2, 16'h0402}) begin
            miscompares++;
            $display("FAIL err_run_start got=%h want=%h", {err, fetch_valid, fetch_pc, fetch_insn}, {CHECK_ON, 1'b1, 4'd2, 16'h0402});
        end
        tick();
        vectors++;
        if ({fetch_pc, fetch_insn} !== {4'd3, 16'h0403}) begin
            miscompares++;
            $display("FAIL err_run_continue got=%h want=%h", {fetch_pc, fetch_insn}, {4'd3, 16'h0403});
        end
        reset = 1'b1; tick(); reset = 1'b0; fetch_ready = 1'b0;
        vectors++;
        if ({ready, fetch_valid, fetch_pc, fetch_insn, r0_value, err} !== {1'b1, 1'b0, 4'd0, 16'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_run got=%h want=%h", {ready, fetch_valid, fetch_pc, fetch_insn, r0_value, err}, {1'b1, 1'b0, 4'd0, 16'd0, 8'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_r0_init();
        test_other_core();
        test_backpressure();
        test_early_done();
        test_protocol_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
